// File: rtl/ct_spsram_1024x92_ctrl_pkg.sv
// Shared constants, FSM encoding and lane helper for the 1024x92 SRAM request controller.
`timescale 1ns/1ps
package ct_spsram_1024x92_ctrl_pkg;

  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = 92;
  localparam int WRAP_SIZE  = 23;
  localparam int LANES      = DATA_WIDTH / WRAP_SIZE;
  localparam int FIFO_DEPTH = 3;

  // Last address written by the zero-clear sweep.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Expand a per-lane write mask (1 = write) into the SRAM's active-low per-bit WEN.
  function automatic logic [DATA_WIDTH-1:0] lane_wen(input logic [LANES-1:0] mask);
    logic [DATA_WIDTH-1:0] wen;
    wen = '1;
    for (int k = 0; k < LANES; k++) begin
      wen[k*WRAP_SIZE +: WRAP_SIZE] = {WRAP_SIZE{~mask[k]}};
    end
    return wen;
  endfunction

endpackage

// File: rtl/ct_spsram_ctrl_rsp_fifo.sv
// 3-entry read-response FIFO; head entry is presented combinationally, count is registered.
`timescale 1ns/1ps
module ct_spsram_ctrl_rsp_fifo
  import ct_spsram_1024x92_ctrl_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  vld,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            count
);

  localparam logic [1:0] LAST_IDX = 2'(FIFO_DEPTH - 1);
  localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  do_push, do_pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
  endfunction

  // Pointer and count update; a push into a full FIFO is allowed only alongside a pop.
  always_comb begin
    // NOTE: every signal gets a default at the top of a combinational block so no path leaves it unassigned (no latch).
    do_pop   = pop & (cnt_q != 2'd0);
    do_push  = push & ((cnt_q != FULL_CNT) | do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Data storage.
  always_ff @(posedge CLK) begin
    // NOTE: storage is not reset; an entry is only observed once count marks it valid.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (do_push && (wr_ptr_q == 2'(i))) mem_q[i] <= push_data;
    end
  end

  // Head entry select.
  always_comb begin
    head_data = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (rd_ptr_q == 2'(i)) head_data = mem_q[i];
    end
  end

  assign vld   = (cnt_q != 2'd0);
  assign count = cnt_q;

endmodule

// File: rtl/ct_spsram_1024x92_ctrl.sv
// Request controller in front of the 1024x92 single-port SRAM: zero-clear sweep,
// valid/ready request conversion to SRAM port cycles, read data through a 3-entry FIFO.
`timescale 1ns/1ps
module ct_spsram_1024x92_ctrl
  import ct_spsram_1024x92_ctrl_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [LANES-1:0]      req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [1:0]            fifo_count;
  logic [1:0]            occ;
  logic                  accept;
  logic                  rd_accept;

  // Reads in flight: queued responses plus the one whose data arrives from the SRAM this cycle.
  assign occ       = fifo_count + {1'b0, rd_pend_q};
  assign accept    = req_vld & req_rdy;
  assign rd_accept = accept & ~req_wr;
  assign init_done = (state_q == ST_RUN);

  // State register, clear-sweep counter and pending-read flag.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (RST) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  // Next-state logic; a request accepted alongside init_req finishes before the re-clear.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_pend_d = rd_accept;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (init_req) begin
          if ((occ == 2'd0) && !rd_accept) begin
            state_d = ST_INIT;
            cnt_d   = '0;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (occ == 2'd0) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: request ready and SRAM port drive.
  always_comb begin
    req_rdy   = (state_q == ST_RUN) && (req_wr || (occ < 2'd3));
    sram_a    = req_addr;
    sram_d    = req_wdata;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    if (state_q == ST_INIT) begin
      sram_a    = cnt_q;
      sram_d    = '0;
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
    end else if (accept) begin
      if (req_wr) begin
        // An all-zero mask is accepted but leaves the SRAM unselected.
        sram_cen  = ~|req_wmask;
        sram_gwen = 1'b0;
        sram_wen  = lane_wen(req_wmask);
      end else begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b1;
      end
    end
  end

  ct_spsram_ctrl_rsp_fifo u_rsp_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (rd_pend_q),
    .push_data (sram_q),
    .pop       (rsp_rdy),
    .vld       (rsp_vld),
    .head_data (rsp_rdata),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ct_spsram_1024x92_ctrl.sv
// Self-checking bench: behavioural SRAM, reference memory and response scoreboard.
`timescale 1ns/1ps
module tb_ct_spsram_1024x92_ctrl;
  import ct_spsram_1024x92_ctrl_pkg::*;

  localparam logic [DATA_WIDTH-1:0] ONES = '1;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic                  init_req;
  logic                  init_done;
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [LANES-1:0]      req_wmask;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q = '0;

  int n_assert = 0;
  int n_fail   = 0;
  int stall_cnt;
  int n_init;

  logic [DATA_WIDTH-1:0] exp_q [$];
  logic [DATA_WIDTH-1:0] ref_mem  [1024];
  logic [DATA_WIDTH-1:0] sram_mem [1024];

  always #5 CLK = ~CLK;

  ct_spsram_1024x92_ctrl dut (
    .CLK       (CLK),
    .RST       (RST),
    .init_req  (init_req),
    .init_done (init_done),
    .req_vld   (req_vld),
    .req_rdy   (req_rdy),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_vld   (rsp_vld),
    .rsp_rdy   (rsp_rdy),
    .rsp_rdata (rsp_rdata),
    .sram_a    (sram_a),
    .sram_cen  (sram_cen),
    .sram_gwen (sram_gwen),
    .sram_wen  (sram_wen),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  task automatic check(input string tag, input logic [DATA_WIDTH-1:0] obs,
                       input logic [DATA_WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_WIDTH-1:0] rand_data();
    return DATA_WIDTH'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Behavioural SRAM: per-bit active-low write enable, Q valid the cycle after a read.
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_gwen) sram_mem[sram_a] = (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= sram_mem[sram_a];
    end
  end

  // Scoreboard: compare popped responses, then record the request accepted this cycle.
  always @(negedge CLK) begin
    if (!RST) begin
      if (rsp_vld && rsp_rdy) begin
        if (exp_q.size() == 0) check("spurious_rsp", DATA_WIDTH'(rsp_vld), '0);
        else                   check("rsp_data", rsp_rdata, exp_q.pop_front());
      end
      if (req_vld && req_rdy) begin
        if (req_wr) begin
          for (int k = 0; k < LANES; k++) begin
            if (req_wmask[k])
              ref_mem[req_addr][k*WRAP_SIZE +: WRAP_SIZE] = req_wdata[k*WRAP_SIZE +: WRAP_SIZE];
          end
        end else begin
          exp_q.push_back(ref_mem[req_addr]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input logic vld, input logic wr, input logic [ADDR_WIDTH-1:0] a,
                         input logic [DATA_WIDTH-1:0] d, input logic [LANES-1:0] m);
    req_vld   = vld;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
  endtask

  // Present one request and hold it until accepted; cycles spent waiting add to stall_cnt.
  task automatic do_req(input logic wr, input logic [ADDR_WIDTH-1:0] a,
                        input logic [DATA_WIDTH-1:0] d, input logic [LANES-1:0] m);
    logic got;
    got = 1'b0;
    set_req(1'b1, wr, a, d, m);
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (req_rdy) begin
        got = 1'b1;
        break;
      end
      stall_cnt++;
      tick();
    end
    if (!got) check("req_accept_timeout", DATA_WIDTH'(req_rdy), DATA_WIDTH'(1));
    tick();
    req_vld = 1'b0;
  endtask

  // Wait for init_done, counting clear-write cycles seen on the SRAM port.
  task automatic wait_init(output int n);
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (init_done === 1'b1) break;
      if (!sram_cen && !sram_gwen) n++;
    end
    check("init_done_rise", DATA_WIDTH'(init_done), DATA_WIDTH'(1));
    tick();
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
  endtask

  task automatic idle_check_empty(input string tag);
    repeat (5) tick();
    @(negedge CLK);
    #1;
    check(tag, DATA_WIDTH'(exp_q.size()), '0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    for (int i = 0; i < 1024; i++) sram_mem[i] = rand_data();
    clear_ref();
    stall_cnt = 0;
    RST       = 1'b1;
    init_req  = 1'b0;
    rsp_rdy   = 1'b1;
    set_req(1'b1, 1'b1, '0, '0, '1);
    repeat (3) @(posedge CLK);
    #1;
    check("reset_init_done", DATA_WIDTH'(init_done), '0);
    check("reset_rsp_vld",   DATA_WIDTH'(rsp_vld),   '0);
    check("reset_req_rdy",   DATA_WIDTH'(req_rdy),   '0);
    set_req(1'b0, 1'b0, '0, '0, '0);
    RST = 1'b0;

    // Clear sweep: address i driven in cycle i, init_done rises after 1024 edges.
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge CLK);
      if (sram_a !== i[ADDR_WIDTH-1:0] || sram_cen !== 1'b0 || sram_gwen !== 1'b0 ||
          sram_wen !== '0 || sram_d !== '0 || init_done !== 1'b0 || req_rdy !== 1'b0) bad++;
      @(posedge CLK);
    end
    #1;
    check("clear_seq", DATA_WIDTH'(bad), '0);
    check("init_done_1024", DATA_WIDTH'(init_done), DATA_WIDTH'(1));

    // Read the last cleared entry and check the two-cycle latency.
    do_req(1'b0, 10'h3FF, '0, '0);
    @(negedge CLK);
    check("lat_n1_rsp_vld", DATA_WIDTH'(rsp_vld), '0);
    @(negedge CLK);
    check("lat_n2_rsp_vld", DATA_WIDTH'(rsp_vld), DATA_WIDTH'(1));
    tick();

    // Full write then immediate read of the same address.
    do_req(1'b1, 10'd5, ONES, 4'b1111);
    do_req(1'b0, 10'd5, '0, '0);

    // Partial-lane write over all ones, then a mask-0 write that must not touch the SRAM.
    do_req(1'b1, 10'd7, ONES, 4'b1111);
    set_req(1'b1, 1'b1, 10'd7, '0, 4'b0101);
    @(negedge CLK);
    check("lane_wen", sram_wen, {{WRAP_SIZE{1'b1}}, {WRAP_SIZE{1'b0}}, {WRAP_SIZE{1'b1}}, {WRAP_SIZE{1'b0}}});
    check("lane_cen", DATA_WIDTH'(sram_cen), '0);
    check("lane_a",   DATA_WIDTH'(sram_a), DATA_WIDTH'(7));
    tick();
    set_req(1'b1, 1'b1, 10'd7, rand_data(), 4'b0000);
    @(negedge CLK);
    check("mask0_cen", DATA_WIDTH'(sram_cen), DATA_WIDTH'(1));
    check("mask0_rdy", DATA_WIDTH'(req_rdy),  DATA_WIDTH'(1));
    tick();
    do_req(1'b0, 10'd7, '0, '0);
    req_vld = 1'b0;
    idle_check_empty("lanes_drained");

    // Eight back-to-back reads with rsp_rdy held high: no stalls, one response per cycle.
    for (int i = 0; i < 8; i++) do_req(1'b1, 10'(16 + i), rand_data(), 4'b1111);
    stall_cnt = 0;
    for (int i = 0; i < 8; i++) do_req(1'b0, 10'(16 + i), '0, '0);
    check("burst_stalls", DATA_WIDTH'(stall_cnt), '0);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("burst_throughput", DATA_WIDTH'(exp_q.size()), '0);
    tick();

    // Back-pressure: three reads fill the pipeline, a fourth read waits, writes still go.
    rsp_rdy   = 1'b0;
    stall_cnt = 0;
    for (int i = 0; i < 3; i++) do_req(1'b0, 10'(16 + i), '0, '0);
    check("bp_stalls", DATA_WIDTH'(stall_cnt), '0);
    set_req(1'b1, 1'b0, 10'd19, '0, '0);
    @(negedge CLK);
    check("bp_rdy_full", DATA_WIDTH'(req_rdy), '0);
    tick();
    @(negedge CLK);
    check("bp_rdy_hold", DATA_WIDTH'(req_rdy), '0);
    check("bp_rsp_vld",  DATA_WIDTH'(rsp_vld), DATA_WIDTH'(1));
    tick();
    set_req(1'b1, 1'b1, 10'd40, rand_data(), 4'b1111);
    @(negedge CLK);
    check("bp_wr_rdy", DATA_WIDTH'(req_rdy), DATA_WIDTH'(1));
    tick();
    rsp_rdy = 1'b1;
    do_req(1'b0, 10'd19, '0, '0);
    do_req(1'b0, 10'd40, '0, '0);
    idle_check_empty("bp_drained");

    // init_req with two reads outstanding: drain, then a full re-clear.
    rsp_rdy = 1'b0;
    do_req(1'b0, 10'd16, '0, '0);
    do_req(1'b0, 10'd17, '0, '0);
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    clear_ref();
    set_req(1'b1, 1'b0, 10'd5, '0, '0);
    @(negedge CLK);
    check("drain_init_done", DATA_WIDTH'(init_done), '0);
    check("drain_rdy",       DATA_WIDTH'(req_rdy),   '0);
    tick();
    tick();
    @(negedge CLK);
    check("drain_no_clear", DATA_WIDTH'(sram_cen), DATA_WIDTH'(1));
    check("drain_rsp_held", DATA_WIDTH'(rsp_vld),  DATA_WIDTH'(1));
    tick();
    req_vld = 1'b0;
    rsp_rdy = 1'b1;
    fork
      wait_init(n_init);
      begin
        repeat (30) tick();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
      end
    join
    check("reinit_cycles", DATA_WIDTH'(n_init), DATA_WIDTH'(1024));
    check("drain_delivered", DATA_WIDTH'(exp_q.size()), '0);
    do_req(1'b0, 10'd5, '0, '0);
    do_req(1'b0, 10'd7, '0, '0);
    do_req(1'b0, 10'h3FF, '0, '0);
    for (int i = 0; i < 8; i++) do_req(1'b0, 10'(16 + i), '0, '0);
    do_req(1'b0, 10'd40, '0, '0);
    idle_check_empty("reinit_drained");

    // RST in the middle of a read burst discards everything in flight.
    do_req(1'b1, 10'd3, rand_data(), 4'b1111);
    rsp_rdy = 1'b0;
    for (int i = 0; i < 3; i++) do_req(1'b0, 10'd3, '0, '0);
    @(negedge CLK);
    check("pre_rst_rsp_vld", DATA_WIDTH'(rsp_vld), DATA_WIDTH'(1));
    tick();
    RST = 1'b1;
    #1;
    check("rst_rsp_vld",   DATA_WIDTH'(rsp_vld),   '0);
    check("rst_req_rdy",   DATA_WIDTH'(req_rdy),   '0);
    check("rst_init_done", DATA_WIDTH'(init_done), '0);
    exp_q.delete();
    clear_ref();
    rsp_rdy = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    wait_init(n_init);
    check("rst_init_cycles", DATA_WIDTH'(n_init), DATA_WIDTH'(1024));
    @(negedge CLK);
    check("post_rst_rsp_vld", DATA_WIDTH'(rsp_vld), '0);
    tick();
    do_req(1'b0, 10'd3, '0, '0);
    idle_check_empty("post_rst_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
